// File: rtl/toy_pack.sv
// rtl/toy_pack.sv - shared physical/architectural register sizing for the rename block
package toy_pack;
  localparam int PHY_REG_NUM      = 64;
  localparam int ARCH_REG_NUM     = 32;
  localparam int PHY_REG_ID_WIDTH = $clog2(PHY_REG_NUM);
endpackage

// File: rtl/toy_rename_freelist.sv
// rtl/toy_rename_freelist.sv - physical register free list with speculative and committed heads
module toy_rename_freelist #(
  parameter int PHY_REG_NUM  = toy_pack::PHY_REG_NUM,
  parameter int ARCH_REG_NUM = toy_pack::ARCH_REG_NUM
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             alloc_req,
  output logic                                             alloc_vld,
  output logic [toy_pack::PHY_REG_ID_WIDTH-1:0]            reg_rd_allocate_id,
  input  logic                                             commit_alloc_en,
  input  logic                                             commit_rel_en,
  input  logic [toy_pack::PHY_REG_ID_WIDTH-1:0]            commit_rel_phy_id,
  input  logic                                             cancel_edge_en,
  output logic [$clog2(PHY_REG_NUM-ARCH_REG_NUM+1)-1:0]    free_cnt,
  output logic                                             fl_err
);

  localparam int FL_DEPTH = PHY_REG_NUM - ARCH_REG_NUM;
  localparam int IDX_W    = (FL_DEPTH > 1) ? $clog2(FL_DEPTH) : 1;
  localparam int PTR_W    = IDX_W + 1;
  localparam int CNT_W    = $clog2(FL_DEPTH + 1);
  localparam int ID_W     = toy_pack::PHY_REG_ID_WIDTH;

  // Pointers carry a wrap bit above the index so full and empty are distinguishable.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p[IDX_W-1:0] == IDX_W'(FL_DEPTH - 1))
      return {~p[PTR_W-1], {IDX_W{1'b0}}};
    return p + PTR_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] ptr_dist(input logic [PTR_W-1:0] a,
                                                input logic [PTR_W-1:0] b);
    int d;
    d = int'(a[IDX_W-1:0]) - int'(b[IDX_W-1:0]);
    if (a[PTR_W-1] != b[PTR_W-1])
      d = d + FL_DEPTH;
    return CNT_W'(d);
  endfunction

  logic [ID_W-1:0]  r_mem [FL_DEPTH];
  logic [PTR_W-1:0] r_spec_head;
  logic [PTR_W-1:0] r_cmt_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_free_cnt;
  logic             r_fl_err;

  logic             w_alloc_vld;
  logic             w_fire;
  logic             w_rel_zero;
  logic             w_fl_full;
  logic             w_rel_ok;
  logic             w_cmt_bad;
  logic             w_cmt_ok;
  logic [PTR_W-1:0] w_cmt_nxt;
  logic [PTR_W-1:0] w_spec_nxt;
  logic [PTR_W-1:0] w_tail_nxt;
  logic             w_err_set;

  always_comb begin
    w_alloc_vld = (r_spec_head != r_tail);
    w_fire      = alloc_req & w_alloc_vld & ~cancel_edge_en;
    w_rel_zero  = (commit_rel_phy_id == '0);
    w_fl_full   = (ptr_dist(r_tail, r_cmt_head) == CNT_W'(FL_DEPTH));
    w_rel_ok    = commit_rel_en & ~w_rel_zero & ~w_fl_full;
    w_cmt_bad   = commit_alloc_en & (r_cmt_head == r_spec_head);
    w_cmt_ok    = commit_alloc_en & ~w_cmt_bad;
    w_err_set   = (commit_rel_en & ~w_rel_ok) | w_cmt_bad;

    w_cmt_nxt   = w_cmt_ok ? ptr_inc(r_cmt_head) : r_cmt_head;
    w_tail_nxt  = w_rel_ok ? ptr_inc(r_tail) : r_tail;
    // A flush lands on the post-commit head so a same-cycle retire is not re-offered.
    if (cancel_edge_en)
      w_spec_nxt = w_cmt_nxt;
    else if (w_fire)
      w_spec_nxt = ptr_inc(r_spec_head);
    else
      w_spec_nxt = r_spec_head;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FL_DEPTH; i++)
        r_mem[i] <= ID_W'(ARCH_REG_NUM + i);
      r_spec_head <= '0;
      r_cmt_head  <= '0;
      r_tail      <= {1'b1, {IDX_W{1'b0}}};
      r_free_cnt  <= CNT_W'(FL_DEPTH);
      r_fl_err    <= 1'b0;
    end else begin
      if (w_rel_ok)
        r_mem[r_tail[IDX_W-1:0]] <= commit_rel_phy_id;
      r_spec_head <= w_spec_nxt;
      r_cmt_head  <= w_cmt_nxt;
      r_tail      <= w_tail_nxt;
      r_free_cnt  <= ptr_dist(w_tail_nxt, w_spec_nxt);
      r_fl_err    <= r_fl_err | w_err_set;
    end
  end

  assign alloc_vld          = w_alloc_vld;
  assign reg_rd_allocate_id = r_mem[r_spec_head[IDX_W-1:0]];
  assign free_cnt           = r_free_cnt;
  assign fl_err             = r_fl_err;

endmodule

// File: doc/toy_rename_freelist.md
TOY_RENAME_FREELIST -- requirements
Module: toy_rename_freelist

Interface
REQ-001 SHALL take parameter PHY_REG_NUM, default 64, the total number of physical registers.
REQ-002 SHALL take parameter ARCH_REG_NUM, default 32, the number of architectural registers; FL_DEPTH = PHY_REG_NUM - ARCH_REG_NUM.
REQ-003 SHALL provide port clk  input  1  the single clock; all state on rising edge.
REQ-004 SHALL provide port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL provide port alloc_req  input  1  rename stage requests one destination physical register.
REQ-006 SHALL provide port alloc_vld  output  1  freelist non-empty; an ID is offered.
REQ-007 SHALL provide port reg_rd_allocate_id  output  PHY_REG_ID_WIDTH  offered physical ID (head of speculative list).
REQ-008 SHALL provide port commit_alloc_en  input  1  the retiring instruction consumed one allocation.
REQ-009 SHALL provide port commit_rel_en  input  1  the retiring instruction frees its old physical ID.
REQ-010 SHALL provide port commit_rel_phy_id  input  PHY_REG_ID_WIDTH  old physical ID being freed.
REQ-011 SHALL provide port cancel_edge_en  input  1  pipeline flush; roll the speculative head back to the committed head.
REQ-012 SHALL provide port free_cnt  output  $clog2(FL_DEPTH+1)  number of IDs currently allocatable.
REQ-013 SHALL provide port fl_err  output  1  sticky protocol-violation flag.

Function
REQ-014 Storage SHALL be a circular array of FL_DEPTH entries with spec_head, cmt_head and tail pointers, each one bit wider than the index (wrap bit).
REQ-015 alloc_vld SHALL be 1 iff spec_head != tail (full comparison including the wrap bit); reg_rd_allocate_id SHALL equal mem[spec_head] combinationally.
REQ-016 An allocation fire = alloc_req & alloc_vld & ~cancel_edge_en; on fire spec_head SHALL increment by 1 modulo 2*FL_DEPTH.
REQ-017 A same-cycle release SHALL NOT bypass to alloc_vld; an ID written at tail is allocatable from the next cycle.
REQ-018 On commit_rel_en, mem[tail] SHALL receive commit_rel_phy_id and tail SHALL increment; commit_rel_phy_id == 0 SHALL be ignored and set fl_err.
REQ-019 On commit_alloc_en, cmt_head SHALL increment; commit_alloc_en while cmt_head == spec_head SHALL be ignored and set fl_err.
REQ-020 On cancel_edge_en, spec_head SHALL load the next-cycle cmt_head value, including any same-cycle commit_alloc_en increment; alloc_req is ignored in that cycle.
REQ-021 Release with free list full (tail - cmt_head == FL_DEPTH) SHALL be dropped and set fl_err.
REQ-022 free_cnt SHALL be the registered value of tail - spec_head, updated in the same cycle as the pointers.
REQ-023 Alloc, release, commit and cancel in one cycle SHALL all take effect independently per REQ-016..REQ-020.
REQ-024 fl_err SHALL remain set until reset.

Reset
REQ-025 On rst, mem[i] SHALL be ARCH_REG_NUM+i for i in 0..FL_DEPTH-1, matching the architectural map's identity reset.
REQ-026 On rst, spec_head = cmt_head = 0 and tail = FL_DEPTH (wrap bit 1, index 0), giving free_cnt = FL_DEPTH, alloc_vld = 1, reg_rd_allocate_id = ARCH_REG_NUM, fl_err = 0.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight state asynchronously and restore REQ-025/026 values.

Structure
REQ-028 PHY_REG_NUM, ARCH_REG_NUM and PHY_REG_ID_WIDTH SHALL come from toy_pack; FL_DEPTH and the pointer width SHALL be derived locally.
REQ-029 No sub-module SHALL be used; pointer and array logic are inline, and entry storage SHALL be flops (no SRAM macro).

Verification
REQ-030 Reset then 32 back-to-back alloc_req cycles -> IDs 32..63 issued in order, then alloc_vld=0 and free_cnt=0.
REQ-031 Allocate 5, commit_alloc_en x2, cancel_edge_en -> the next reg_rd_allocate_id is 34 and free_cnt is 30.
REQ-032 Drain empty, then commit_rel_en with id 7 together with alloc_req -> no grant that cycle; next cycle alloc_vld=1 and reg_rd_allocate_id=7.
REQ-033 Apply commit_alloc_en and cancel_edge_en in the same cycle after 3 allocations -> spec_head = old cmt_head + 1 and the offered ID is 33.
REQ-034 Release commit_rel_phy_id=0, or release when full -> state unchanged and fl_err=1 held until rst.
REQ-035 Random alloc, commit, release and cancel for 10k cycles against a queue model -> no duplicate outstanding ID, and free_cnt matches the model every cycle.
